// File: rtl/pwrgate_ack_sequencer.sv
// Power-switch acknowledge model: per-domain ramp FSMs returning the active-low
// switch ack after a programmable delay, with sticky done flags and an interrupt.
module pwrgate_ack_sequencer #(
    parameter int unsigned NUM_DOMAINS = 3,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned ON_DELAY    = 16,
    parameter int unsigned OFF_DELAY   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_DOMAINS-1:0] switch_ni,
    input  logic [NUM_DOMAINS-1:0] bypass_i,
    output logic [NUM_DOMAINS-1:0] ack_no,
    output logic [NUM_DOMAINS-1:0] busy_o,
    output logic [NUM_DOMAINS-1:0] done_o,
    output logic [NUM_DOMAINS-1:0] pending_o,
    input  logic [NUM_DOMAINS-1:0] clear_i,
    input  logic [NUM_DOMAINS-1:0] irq_en_i,
    output logic                   irq_o
);

    localparam int unsigned ON_EFF  = (ON_DELAY == 0)  ? 1 : ON_DELAY;
    localparam int unsigned OFF_EFF = (OFF_DELAY == 0) ? 1 : OFF_DELAY;
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_EFF - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_EFF - 1);
    localparam bit ON_DIRECT  = (ON_EFF == 1);
    localparam bit OFF_DIRECT = (OFF_EFF == 1);

    if ((64'(ON_DELAY) >= (64'd1 << CNT_W)) || (64'(OFF_DELAY) >= (64'd1 << CNT_W))) begin : g_param_check
        $error("pwrgate_ack_sequencer: ON_DELAY/OFF_DELAY must be below 2**CNT_W");
    end

    typedef enum logic [1:0] {
        ST_ON        = 2'd0,
        ST_RAMP_DOWN = 2'd1,
        ST_OFF       = 2'd2,
        ST_RAMP_UP   = 2'd3
    } state_t;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             ack_q, ack_d;
        logic             busy_q, busy_d;
        logic             done_q, done_d;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= ST_ON;
                cnt_q   <= '0;
                ack_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ack_q   <= ack_d;
                busy_q  <= busy_d;
                done_q  <= done_d;
            end
        end

        // Counter loads on ramp entry and completes when it would reach zero,
        // so the ack lands exactly DELAY edges after the first sampling edge.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ack_d   = ack_q;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            if (bypass_i[i]) begin
                state_d = switch_ni[i] ? ST_OFF : ST_ON;
                cnt_d   = '0;
                ack_d   = switch_ni[i];
            end else begin
                case (state_q)
                    ST_ON: begin
                        if (switch_ni[i]) begin
                            if (OFF_DIRECT) begin
                                state_d = ST_OFF;
                                ack_d   = 1'b1;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_RAMP_DOWN;
                                cnt_d   = OFF_LOAD;
                            end
                        end
                    end
                    ST_RAMP_DOWN: begin
                        if (!switch_ni[i]) begin
                            state_d = ST_ON;
                            cnt_d   = '0;
                        end else if (cnt_q <= CNT_W'(1)) begin
                            state_d = ST_OFF;
                            cnt_d   = '0;
                            ack_d   = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    ST_OFF: begin
                        if (!switch_ni[i]) begin
                            if (ON_DIRECT) begin
                                state_d = ST_ON;
                                ack_d   = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_RAMP_UP;
                                cnt_d   = ON_LOAD;
                            end
                        end
                    end
                    ST_RAMP_UP: begin
                        if (switch_ni[i]) begin
                            state_d = ST_OFF;
                            cnt_d   = '0;
                        end else if (cnt_q <= CNT_W'(1)) begin
                            state_d = ST_ON;
                            cnt_d   = '0;
                            ack_d   = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end
                endcase
            end
            busy_d = (state_d == ST_RAMP_DOWN) || (state_d == ST_RAMP_UP);
        end

        assign ack_no[i] = ack_q;
        assign busy_o[i] = busy_q;
        assign done_o[i] = done_q;
    end

    // Sticky completion flags; a new done beats a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_o <= '0;
            irq_o     <= 1'b0;
        end else begin
            pending_o <= done_o | (pending_o & ~clear_i);
            irq_o     <= |(pending_o & irq_en_i);
        end
    end

endmodule

// File: doc/pwrgate_ack_sequencer.md
Name: pwrgate_ack_sequencer

Overview:
Parametrised power-switch acknowledge model for NUM_DOMAINS power domains: CPU, peripheral and external/CGRA subsystems. It replaces the direct switch-to-ack tie-off with per-domain ramp timing.
- Each domain runs a small FSM.
- Each domain returns its active-low switch acknowledge a programmable number of cycles after a switch request.
- Aborted ramps are handled.
- Completion events are reported via sticky pending bits and one interrupt line, which feeds the external interrupt vector.
- The block sits in the top level between the MCU powergate outputs and their ack inputs.

Parameters:
NUM_DOMAINS, 3, number of independent power domains
CNT_W, 8, ramp counter width; elaboration assertion requires ON_DELAY and OFF_DELAY < 2**CNT_W
ON_DELAY, 16, cycles from power-on request to ack (value 0 treated as 1)
OFF_DELAY, 8, cycles from power-off request to ack (value 0 treated as 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
switch_ni  in  NUM_DOMAINS  per-domain switch request (0 = power on, 1 = power off)
bypass_i  in  NUM_DOMAINS  1 = ack follows switch with 1-cycle latency; no ramp, no done
ack_no  out  NUM_DOMAINS  per-domain switch acknowledge (0 = on acked, 1 = off acked)
busy_o  out  NUM_DOMAINS  1 while the domain is in RAMP_UP or RAMP_DOWN
done_o  out  NUM_DOMAINS  1-cycle pulse when a ramped ack changes
pending_o  out  NUM_DOMAINS  sticky done flags
clear_i  in  NUM_DOMAINS  write-1-to-clear for pending_o
irq_en_i  in  NUM_DOMAINS  per-domain interrupt enable
irq_o  out  1  OR of (pending_o AND irq_en_i), registered

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous, active-high.
- All outputs are registered.
- Reset values, all domains: state ON, ack_no=0, busy_o=0, done_o=0, pending_o=0, irq_o=0, counter=0.
- Reset asserted mid-ramp: immediate return to reset values; no done pulse.
- Per-domain FSM states: ON, RAMP_DOWN, OFF, RAMP_UP.
- ON:
  - switch_ni=1 sampled -> RAMP_DOWN, counter=OFF_DELAY-1.
  - If OFF_DELAY<=1: go directly to OFF, ack_no=1 and done_o=1 at that same edge.
- RAMP_DOWN:
  - Counter decrements each edge.
  - At the edge where the counter is 0: -> OFF, ack_no<=1, done_o<=1.
- OFF / RAMP_UP: symmetric, using ON_DELAY and ack_no<=0.
- Ack latency:
  - Call the first edge that samples the new switch value edge 1.
  - ack_no updates at edge DELAY, i.e. it is visible after DELAY cycles.
- Abort:
  - switch_ni reverts during RAMP_DOWN -> ON at the next edge; ack_no unchanged (0), counter cleared, no done.
  - Same for RAMP_UP -> OFF (ack_no stays 1).
- Pending and interrupt:
  - done_o sets pending_o[i] at the following edge.
  - clear_i[i] clears it.
  - set and clear in the same cycle: set wins.
  - irq_o is registered: irq_o(t+1) = |(pending_o(t) & irq_en_i(t)).
- Bypass:
  - bypass_i[i]=1: ack_no[i] <= switch_ni[i] every edge.
  - FSM is forced to ON/OFF matching switch_ni, counter is cleared, busy_o=0, no done.
  - Assertion during a ramp abandons the ramp without done.
  - Deassertion resumes normal FSM operation from the forced state.
- Domains are fully independent: simultaneous events in different domains are all honoured in the same cycle.
- Counter never wraps: it is loaded only on state entry and saturates at 0.

Test Plan:
1. Reset, then switch_ni[0] 0->1 with OFF_DELAY=8 -> busy_o[0]=1 for 7 cycles; ack_no[0]=1 visible 8 cycles after the first sampling edge; done_o[0] pulses once; pending_o[0]=1 next cycle; with irq_en_i[0]=1, irq_o=1 one cycle later.
2. From OFF, switch_ni[1] 1->0 with ON_DELAY=16, then switch_ni[1] back to 1 at cycle 5 -> FSM returns to OFF; ack_no[1] stays 1; no done_o; pending_o[1] stays 0.
3. clear_i[0] asserted in the same cycle as a new done_o[0] -> pending_o[0] remains 1; clear_i alone the next cycle -> pending_o[0]=0 and irq_o=0 one cycle after that.
4. bypass_i[2]=1, toggle switch_ni[2] at cycles 0, 1, 3 -> ack_no[2] follows with exactly 1-cycle latency; busy_o[2]=0; done_o[2]=0 throughout.
5. Assert rst_i asynchronously mid-RAMP_UP on domain 0 (between clock edges) -> ack_no=0, busy_o=0, pending_o=0 immediately; after release, domain 0 is in ON.
6. Build with ON_DELAY=0, OFF_DELAY=1 -> ack_no follows switch_ni 1 cycle after sampling in both directions; done_o pulses on every change.
